// File: rtl/router_fifo.sv
// router_fifo: per-destination packet buffer of the 1x3 router.
// Each entry carries a header tag so the read side can count down the bytes left in a packet.
module router_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             soft_reset,
    input  logic             write_enb,
    input  logic             read_enb,
    input  logic             lfd_state,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty,
    output logic             pkt_busy
);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [WIDTH:0] mem [DEPTH];
    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;
    logic [6:0]     pkt_cnt;
    logic [WIDTH:0] rd_word;
    logic           flush;
    logic           wr_acc;
    logic           rd_acc;

    assign flush    = rst | soft_reset;
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign wr_acc   = write_enb && !full && !flush;
    assign rd_acc   = read_enb && !empty && !flush;
    assign rd_word  = mem[rd_ptr[AW-1:0]];
    assign pkt_busy = (pkt_cnt != 7'd0);

    // Storage is never cleared; flushing only moves the pointers.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr[AW-1:0]] <= {lfd_state, data_in};
        end
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // Header load covers payload plus the trailing parity byte.
    always_ff @(posedge clk) begin
        if (flush) begin
            pkt_cnt <= 7'd0;
        end else if (rd_acc) begin
            if (rd_word[WIDTH]) begin
                pkt_cnt <= 7'(rd_word[WIDTH-1:2]) + 7'd1;
            end else if (pkt_cnt != 7'd0) begin
                pkt_cnt <= pkt_cnt - 7'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            data_out <= '0;
        end else if (rd_acc) begin
            data_out <= rd_word[WIDTH-1:0];
        end else if (pkt_cnt == 7'd0) begin
            data_out <= '0;
        end
    end

endmodule

// File: tb/tb_router_fifo.sv
// Testbench for router_fifo: queue-based reference model feeding a scoreboard,
// directed packet/boundary scenarios followed by randomized traffic.
module tb_router_fifo;
    logic       clk;
    logic       rst;
    logic       soft_reset;
    logic       write_enb;
    logic       read_enb;
    logic       lfd_state;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       full;
    logic       empty;
    logic       pkt_busy;

    router_fifo #(.WIDTH(8), .DEPTH(16), .AW(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .soft_reset (soft_reset),
        .write_enb  (write_enb),
        .read_enb   (read_enb),
        .lfd_state  (lfd_state),
        .data_in    (data_in),
        .data_out   (data_out),
        .full       (full),
        .empty      (empty),
        .pkt_busy   (pkt_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: contents as a queue of {tag, byte}, bytes left in packet, expected output.
    logic [8:0] mq [$];
    logic [7:0] exp_q [$];
    int         m_cnt;
    logic [7:0] m_dout;
    logic       mon_rd;
    int         n_checks;
    int         n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic cycle(input logic we, input logic re, input logic lfd,
                         input logic [7:0] din, input logic sr, input logic r);
        logic       wa;
        logic       ra;
        logic [8:0] w;
        @(negedge clk);
        check("full", full, 32'(mq.size() == 16));
        check("empty", empty, 32'(mq.size() == 0));
        check("pkt_busy", pkt_busy, 32'(m_cnt != 0));
        check("data_out", data_out, m_dout);
        rst        = r;
        soft_reset = sr;
        write_enb  = we;
        read_enb   = re;
        lfd_state  = lfd;
        data_in    = din;
        if (r || sr) begin
            mq.delete();
            m_cnt  = 0;
            m_dout = 8'h00;
            mon_rd = 1'b0;
        end else begin
            wa     = we && (mq.size() < 16);
            ra     = re && (mq.size() > 0);
            mon_rd = ra;
            if (ra) begin
                w = mq.pop_front();
                exp_q.push_back(w[7:0]);
                m_dout = w[7:0];
                if (w[8]) m_cnt = int'(w[7:2]) + 1;
                else if (m_cnt > 0) m_cnt--;
            end else if (m_cnt == 0) begin
                m_dout = 8'h00;
            end
            if (wa) mq.push_back({lfd, din});
        end
    endtask

    task automatic wr(input logic [7:0] d, input logic lfd);
        cycle(1'b1, 1'b0, lfd, d, 1'b0, 1'b0);
    endtask

    task automatic rd();
        cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    // Scoreboard monitor: after every accepted read edge, data_out must match the queued byte.
    initial begin
        logic [7:0] e;
        forever begin
            @(posedge clk);
            if (mon_rd) begin
                #1;
                if (exp_q.size() == 0) begin
                    check("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_data", data_out, e);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        m_cnt      = 0;
        m_dout     = 8'h00;
        mon_rd     = 1'b0;
        rst        = 1'b1;
        soft_reset = 1'b0;
        write_enb  = 1'b0;
        read_enb   = 1'b0;
        lfd_state  = 1'b0;
        data_in    = 8'h00;
        repeat (2) @(negedge clk);
        idle();

        // reset mid-traffic, then a read must find nothing
        wr(8'h11, 1'b0);
        wr(8'h22, 1'b0);
        rd();
        cycle(1'b1, 1'b1, 1'b0, 8'h33, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 8'h44, 1'b0, 1'b1);
        idle();
        rd();
        idle();

        // packet pass-through
        wr(8'h0D, 1'b1);
        wr(8'hA1, 1'b0);
        wr(8'hA2, 1'b0);
        wr(8'hA3, 1'b0);
        wr(8'h5F, 1'b0);
        repeat (5) rd();
        repeat (2) idle();

        // full boundary with dropped 17th write
        for (int i = 0; i < 16; i++) wr(8'($urandom_range(0, 255)), 1'b0);
        wr(8'hEE, 1'b0);
        repeat (16) rd();
        rd();
        idle();

        // simultaneous write/read while full
        for (int i = 0; i < 16; i++) wr(8'(8'h40 + i), 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 8'h77, 1'b0, 1'b0);
        idle();
        repeat (15) rd();
        idle();

        // soft reset mid-packet together with a write
        wr(8'h0D, 1'b1);
        wr(8'hA1, 1'b0);
        wr(8'hA2, 1'b0);
        wr(8'hA3, 1'b0);
        wr(8'h5F, 1'b0);
        rd();
        rd();
        cycle(1'b1, 1'b0, 1'b0, 8'h99, 1'b1, 1'b0);
        idle();
        rd();
        idle();

        // wrap-around with interleaved pairs
        for (int i = 0; i < 40; i++) begin
            wr(8'(i), 1'b0);
            rd();
        end
        idle();

        // randomized traffic: fill-biased then drain-biased phases
        for (int i = 0; i < 600; i++) begin
            logic we;
            logic re;
            logic lfd;
            logic sr;
            logic r;
            if ((i / 100) % 2 == 0) begin
                we = ($urandom_range(0, 3) != 0);
                re = ($urandom_range(0, 3) == 0);
            end else begin
                we = ($urandom_range(0, 3) == 0);
                re = ($urandom_range(0, 3) != 0);
            end
            lfd = ($urandom_range(0, 5) == 0);
            sr  = ($urandom_range(0, 80) == 0);
            r   = ($urandom_range(0, 200) == 0);
            cycle(we, re, lfd, 8'($urandom_range(0, 255)), sr, r);
        end
        repeat (20) rd();
        repeat (2) idle();

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
